// File: rtl/frame_buf_pkg.sv
// Shared definitions for the frame-buffer write/read burst generators:
// FSM states, bank width and the default address mapping.
package frame_buf_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DATA = 2'd2
    } fb_state_e;

    localparam int BANK_W          = 2;
    localparam int BANK_LOG2_DEF   = 23;
    localparam int BEAT_LOG2_DEF   = 4;
    localparam int FRAME_BEATS_DEF = 115200;

endpackage

// File: rtl/vs_edge_sync.sv
// Two-flop synchronizer for an asynchronous vsync plus a rising-edge detector
// on the synchronized level; rise_o is a single-cycle pulse.
module vs_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic vs_i,
    output logic rise_o
);

    logic [1:0] sync_q;
    logic       d1_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= 2'b00;
            d1_q   <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], vs_i};
            d1_q   <= sync_q[1];
        end
    end

    assign rise_o = sync_q[1] & ~d1_q;

endmodule

// File: rtl/frame_wr_burst_gen.sv
// Turns camera beats queued in the write FIFO into DDR write bursts addressed
// into the bank latched at frame start. Define FRAME_WR_STAT_EN for frame/drop counters.
module frame_wr_burst_gen
    import frame_buf_pkg::*;
#(
    parameter int ADDR_W      = 28,
    parameter int BANK_LOG2   = BANK_LOG2_DEF,
    parameter int BEAT_LOG2   = BEAT_LOG2_DEF,
    parameter int BURST_LEN   = 64,
    parameter int FRAME_BEATS = FRAME_BEATS_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              vin_vs,
    input  logic [1:0]        wr_bank,
    input  logic [9:0]        fifo_cnt,
    output logic              fifo_rd_en,
    output logic              wr_cmd_valid,
    input  logic              wr_cmd_ready,
    output logic [ADDR_W-1:0] wr_cmd_addr,
    output logic [7:0]        wr_cmd_len,
    input  logic              wr_data_ready,
    output logic              wr_data_last,
    output logic              frame_done,
    output logic              frame_err,
    output logic [15:0]       stat_frames,
    output logic [15:0]       stat_drops
);

    localparam int REM_W = $clog2(FRAME_BEATS + 1);

    fb_state_e          state_q;
    logic               active_q;
    logic               sof_pend_q;
    logic [BANK_W-1:0]  cur_bank_q;
    logic [ADDR_W-1:0]  beat_addr_q;
    logic [REM_W-1:0]   remain_q;
    logic [7:0]         beat_cnt_q;
    logic               cmd_valid_q;
    logic [ADDR_W-1:0]  cmd_addr_q;
    logic [7:0]         cmd_len_q;
    logic               done_q;
    logic               err_q;

    logic               sof;
    logic [7:0]         len_nxt_d;
    logic [ADDR_W-1:0]  addr_nxt_d;
    logic               last_beat_d;

    vs_edge_sync u_vs_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .vs_i   (vin_vs),
        .rise_o (sof)
    );

    always_comb begin
        len_nxt_d   = (int'(remain_q) > BURST_LEN) ? 8'(BURST_LEN) : 8'(remain_q);
        addr_nxt_d  = (ADDR_W'(cur_bank_q) << BANK_LOG2) + (beat_addr_q << BEAT_LOG2);
        last_beat_d = (beat_cnt_q == cmd_len_q - 8'd1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            active_q    <= 1'b0;
            sof_pend_q  <= 1'b0;
            cur_bank_q  <= '0;
            beat_addr_q <= '0;
            remain_q    <= '0;
            beat_cnt_q  <= '0;
            cmd_valid_q <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_len_q   <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    // A pending frame start takes priority over issuing a burst of the old frame.
                    if (sof_pend_q) begin
                        beat_addr_q <= '0;
                        remain_q    <= REM_W'(FRAME_BEATS);
                        active_q    <= 1'b1;
                        sof_pend_q  <= 1'b0;
                    end else if (active_q && (fifo_cnt >= {2'b00, len_nxt_d})) begin
                        state_q     <= ST_REQ;
                        cmd_valid_q <= 1'b1;
                        cmd_addr_q  <= addr_nxt_d;
                        cmd_len_q   <= len_nxt_d;
                    end
                end
                ST_REQ: begin
                    if (wr_cmd_ready) begin
                        state_q     <= ST_DATA;
                        cmd_valid_q <= 1'b0;
                        beat_cnt_q  <= '0;
                    end
                end
                ST_DATA: begin
                    if (wr_data_ready) begin
                        beat_cnt_q <= beat_cnt_q + 8'd1;
                        if (last_beat_d) begin
                            state_q     <= ST_IDLE;
                            beat_addr_q <= beat_addr_q + ADDR_W'(cmd_len_q);
                            remain_q    <= remain_q - REM_W'(cmd_len_q);
                            if (int'(remain_q) == int'(cmd_len_q)) begin
                                done_q   <= 1'b1;
                                active_q <= 1'b0;
                            end
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
            // Placed after the FSM so a new frame start wins over consuming the previous one.
            if (sof) begin
                cur_bank_q <= wr_bank;
                sof_pend_q <= 1'b1;
                err_q      <= active_q | sof_pend_q;
            end
        end
    end

    assign fifo_rd_en   = (state_q == ST_DATA) & wr_data_ready;
    assign wr_data_last = (state_q == ST_DATA) & last_beat_d;
    assign wr_cmd_valid = cmd_valid_q;
    assign wr_cmd_addr  = cmd_addr_q;
    assign wr_cmd_len   = cmd_len_q;
    assign frame_done   = done_q;
    assign frame_err    = err_q;

`ifdef FRAME_WR_STAT_EN
    logic [15:0] frames_q;
    logic [15:0] drops_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frames_q <= '0;
            drops_q  <= '0;
        end else begin
            if (done_q && (frames_q != 16'hFFFF)) frames_q <= frames_q + 16'd1;
            if (err_q && (drops_q != 16'hFFFF))   drops_q  <= drops_q + 16'd1;
        end
    end

    assign stat_frames = frames_q;
    assign stat_drops  = drops_q;
`else
    assign stat_frames = 16'd0;
    assign stat_drops  = 16'd0;
`endif

endmodule
